// File: rtl/regfile_wr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arb_if
//  Description : Bundle of requester, register-file write and read-bypass
//                signals for the regfile_wr_arb write arbiter. Signal
//                suffixes are relative to the arbiter (slave side).
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_wr_arb_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          hold_i;
    logic          req0_i;
    logic          req1_i;
    logic          req2_i;
    logic [AW-1:0] addr0_i;
    logic [AW-1:0] addr1_i;
    logic [AW-1:0] addr2_i;
    logic [DW-1:0] data0_i;
    logic [DW-1:0] data1_i;
    logic [DW-1:0] data2_i;
    logic          gnt0_o;
    logic          gnt1_o;
    logic          gnt2_o;
    logic [AW-1:0] wa_o;
    logic [DW-1:0] wd_o;
    logic          we1_o;
    logic [AW-1:0] ra1_i;
    logic [AW-1:0] ra2_i;
    logic [DW-1:0] rd1_in_i;
    logic [DW-1:0] rd2_in_i;
    logic [DW-1:0] rd1_o;
    logic [DW-1:0] rd2_o;

    modport slave (
        input  hold_i, req0_i, req1_i, req2_i,
        input  addr0_i, addr1_i, addr2_i, data0_i, data1_i, data2_i,
        input  ra1_i, ra2_i, rd1_in_i, rd2_in_i,
        output gnt0_o, gnt1_o, gnt2_o, wa_o, wd_o, we1_o, rd1_o, rd2_o
    );

    modport master (
        output hold_i, req0_i, req1_i, req2_i,
        output addr0_i, addr1_i, addr2_i, data0_i, data1_i, data2_i,
        output ra1_i, ra2_i, rd1_in_i, rd2_in_i,
        input  gnt0_o, gnt1_o, gnt2_o, wa_o, wd_o, we1_o, rd1_o, rd2_o
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arb
//  Description : Three-requester round-robin write arbiter for a register
//                file. Grants are combinational; the granted write is
//                registered and presented to the register file one cycle
//                later. Optional read bypass forwards the pending write to
//                the read ports, enabled by defining REGFILE_WR_BYPASS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wr_arb #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    regfile_wr_arb_if.slave bus
);

    logic [1:0]    ptr_q;
    logic [1:0]    ptr_d;
    logic          we1_q;
    logic [AW-1:0] wa_q;
    logic [DW-1:0] wd_q;

    logic [3:0]    w_req;
    logic [5:0]    w_ord;
    logic          w_any;
    logic [1:0]    w_win;
    logic [2:0]    w_gnt;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    // Round-robin pick: scan requesters starting at ptr_q, first hit wins
    always_comb begin
        w_req = {1'b0, bus.req2_i, bus.req1_i, bus.req0_i};
        case (ptr_q)
            2'd1:    w_ord = {2'd0, 2'd2, 2'd1};
            2'd2:    w_ord = {2'd1, 2'd0, 2'd2};
            default: w_ord = {2'd2, 2'd1, 2'd0};
        endcase
        w_any = 1'b0;
        w_win = 2'd0;
        if (!bus.hold_i && !rst) begin
            for (int j = 0; j < 3; j++) begin
                if (!w_any && w_req[w_ord[2*j +: 2]]) begin
                    w_any = 1'b1;
                    w_win = w_ord[2*j +: 2];
                end
            end
        end
    end

    // Decode winner into one-hot grants and select its write payload
    always_comb begin
        w_gnt  = 3'b000;
        w_addr = bus.addr0_i;
        w_data = bus.data0_i;
        case (w_win)
            2'd1: begin
                w_addr = bus.addr1_i;
                w_data = bus.data1_i;
            end
            2'd2: begin
                w_addr = bus.addr2_i;
                w_data = bus.data2_i;
            end
            default: begin
                w_addr = bus.addr0_i;
                w_data = bus.data0_i;
            end
        endcase
        if (w_any) begin
            w_gnt[w_win] = 1'b1;
        end
        ptr_d = ptr_q;
        if (w_any) begin
            ptr_d = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
        end
    end

    // Pointer and write-port registers; reset discards any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
            we1_q <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            we1_q <= w_any;
            if (w_any) begin
                wa_q <= w_addr;
                wd_q <= w_data;
            end
        end
    end

    assign bus.gnt0_o = w_gnt[0];
    assign bus.gnt1_o = w_gnt[1];
    assign bus.gnt2_o = w_gnt[2];
    assign bus.we1_o  = we1_q;
    assign bus.wa_o   = wa_q;
    assign bus.wd_o   = wd_q;

`ifdef REGFILE_WR_BYPASS_EN
    // Forward the write that has not yet reached the register file
    assign bus.rd1_o = (we1_q && (bus.ra1_i == wa_q)) ? wd_q : bus.rd1_in_i;
    assign bus.rd2_o = (we1_q && (bus.ra2_i == wa_q)) ? wd_q : bus.rd2_in_i;
`else
    // Read addresses only matter when forwarding is built in
    logic w_unused_ra;
    assign w_unused_ra = ^{bus.ra1_i, bus.ra2_i};
    assign bus.rd1_o   = bus.rd1_in_i;
    assign bus.rd2_o   = bus.rd2_in_i;
`endif

endmodule
`default_nettype wire
